altpcie_pll_phase_step: RTL and testbench

Drives the PLL dynamic phase-shift port on behalf of the PCLK phase aligner. It sits directly downstream of the aligner. It turns the aligner's level step request and direction into a correctly timed PLL phasestep pulse, then tracks the PLL's phasedone handshake. When the shift completes, it returns an active-low completion to the aligner. It also keeps a signed running tap position for debug and flags a PLL that never answers.

---
 rtl/altpcie_pll_phase_step_if.sv | 31 +++
 rtl/altpcie_pll_phase_step.sv | 137 +++++++++++++
 tb/tb_altpcie_pll_phase_step.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/altpcie_pll_phase_step_if.sv
// Signal bundle between the PCLK phase aligner, this stepper and the PLL
// dynamic phase-shift port. The slave side is the stepper itself.
interface altpcie_pll_phase_step_if;
   logic       step_req;
   logic       step_dir;
   logic       step_done_n;
   logic [3:0] pll_phasecounterselect;
   logic       pll_phaseupdown;
   logic       pll_phasestep;
   logic       pll_phasedone;

   modport master (
      output step_req,
      output step_dir,
      output pll_phasedone,
      input  step_done_n,
      input  pll_phasecounterselect,
      input  pll_phaseupdown,
      input  pll_phasestep
   );

   modport slave (
      input  step_req,
      input  step_dir,
      input  pll_phasedone,
      output step_done_n,
      output pll_phasecounterselect,
      output pll_phaseupdown,
      output pll_phasestep
   );
endinterface

// File: rtl/altpcie_pll_phase_step.sv
// Turns the aligner's level step request into a timed PLL phasestep pulse,
// tracks the phasedone handshake, and keeps a saturating signed tap count.
module altpcie_pll_phase_step #(
   parameter logic [3:0] CNT_SEL      = 4'b0000,
   parameter int         STEP_HOLD    = 2,
   parameter int         DONE_TIMEOUT = 255
) (
   input  logic                      clock,
   input  logic                      rst,
   altpcie_pll_phase_step_if.slave   bus,
   output logic                      busy,
   output logic signed [7:0]         tap_pos,
   output logic                      timeout_err
);

   localparam logic [3:0] HOLD_LOAD   = 4'(STEP_HOLD);
   localparam logic [7:0] TIMEOUT_LIM = 8'(DONE_TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STEP,
      WAIT_LO,
      WAIT_HI,
      ACK
   } state_t;

   state_t             state;
   logic               done_meta;
   logic               done_s;
   logic [3:0]         hold_cnt;
   logic [7:0]         timer;
   logic [7:0]         timer_inc;
   logic signed [7:0]  tap_next;

   // phasedone is launched from the PLL with no relation to our clock; idle level is 1.
   always_ff @(posedge clock) begin
      if (rst) begin
         done_meta <= 1'b1;
         done_s    <= 1'b1;
      end else begin
         done_meta <= bus.pll_phasedone;
         done_s    <= done_meta;
      end
   end

   assign timer_inc = (timer == 8'hFF) ? timer : timer + 8'd1;

   // Direction comes from the latched copy so late step_dir wiggles cannot skew the count.
   always_comb begin
      tap_next = tap_pos;
      if (bus.pll_phaseupdown) begin
         if (tap_pos != 8'sh80) tap_next = tap_pos - 8'sd1;
      end else begin
         if (tap_pos != 8'sh7F) tap_next = tap_pos + 8'sd1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state                      <= IDLE;
         bus.step_done_n            <= 1'b1;
         bus.pll_phasecounterselect <= CNT_SEL;
         bus.pll_phaseupdown        <= 1'b0;
         bus.pll_phasestep          <= 1'b0;
         busy                       <= 1'b0;
         tap_pos                    <= 8'sd0;
         timeout_err                <= 1'b0;
         hold_cnt                   <= 4'd0;
         timer                      <= 8'd0;
      end else begin
         bus.pll_phasecounterselect <= CNT_SEL;
         case (state)
            IDLE: begin
               if (bus.step_req) begin
                  bus.pll_phaseupdown <= bus.step_dir;
                  timer               <= 8'd0;
                  busy                <= 1'b1;
                  state               <= SETUP;
               end
            end
            SETUP: begin
               bus.pll_phasestep <= 1'b1;
               hold_cnt          <= HOLD_LOAD;
               state             <= STEP;
            end
            STEP: begin
               if (hold_cnt <= 4'd1) begin
                  bus.pll_phasestep <= 1'b0;
                  state             <= WAIT_LO;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            WAIT_LO: begin
               if (!done_s) begin
                  timer <= 8'd0;
                  state <= WAIT_HI;
               end else if (timer_inc == TIMEOUT_LIM) begin
                  timeout_err     <= 1'b1;
                  bus.step_done_n <= 1'b0;
                  state           <= ACK;
               end else begin
                  timer <= timer_inc;
               end
            end
            WAIT_HI: begin
               if (done_s) begin
                  tap_pos         <= tap_next;
                  bus.step_done_n <= 1'b0;
                  state           <= ACK;
               end else if (timer_inc == TIMEOUT_LIM) begin
                  timeout_err     <= 1'b1;
                  bus.step_done_n <= 1'b0;
                  state           <= ACK;
               end else begin
                  timer <= timer_inc;
               end
            end
            ACK: begin
               if (!bus.step_req) begin
                  bus.step_done_n <= 1'b1;
                  busy            <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: begin
               bus.pll_phasestep <= 1'b0;
               bus.step_done_n   <= 1'b1;
               busy              <= 1'b0;
               state             <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_altpcie_pll_phase_step.sv
// Directed bench for altpcie_pll_phase_step: expected tap/error values are
// queued per request and compared when the stepper acknowledges.
module tb_altpcie_pll_phase_step;

   localparam int         STEP_HOLD       = 2;
   localparam int         DONE_TIMEOUT    = 8;
   localparam logic [3:0] CNT_SEL         = 4'b1010;
   localparam int         PLL_DROP_DELAY  = 3;
   localparam int         PLL_LOW_CYCLES  = 4;
   // phasestep rises at edge 2, phasedone low after 2+3, high after +4, ack 3 edges later
   localparam int         DONE_LATENCY    = 2 + PLL_DROP_DELAY + PLL_LOW_CYCLES + 3;
   localparam int         TIMEOUT_LATENCY = 2 + STEP_HOLD + DONE_TIMEOUT;
   localparam int         WAIT_BUDGET     = 200;

   typedef struct {
      int tap;
      int err;
      int dir;
   } exp_t;

   logic              clock = 1'b0;
   logic              rst;
   logic              busy;
   logic signed [7:0] tap_pos;
   logic              timeout_err;
   logic              pll_stuck = 1'b0;

   int   checks    = 0;
   int   errors    = 0;
   int   model_tap = 0;
   int   model_err = 0;
   exp_t exp_q[$];

   altpcie_pll_phase_step_if bus();

   altpcie_pll_phase_step #(
      .CNT_SEL      (CNT_SEL),
      .STEP_HOLD    (STEP_HOLD),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .bus         (bus.slave),
      .busy        (busy),
      .tap_pos     (tap_pos),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   // Behavioural PLL: phasedone low for a few cycles after each phasestep, unless stuck.
   initial begin
      bus.pll_phasedone = 1'b1;
      forever begin
         @(posedge bus.pll_phasestep);
         if (!pll_stuck) begin
            repeat (PLL_DROP_DELAY) @(posedge clock);
            #1 bus.pll_phasedone = 1'b0;
            repeat (PLL_LOW_CYCLES) @(posedge clock);
            #1 bus.pll_phasedone = 1'b1;
         end
      end
   end

   function automatic int satTap(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] observed,
                        input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      check("scoreboard_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("step_done_n_ack", bus.step_done_n, 0);
         check("tap_pos", tap_pos, e.tap);
         check("timeout_err", timeout_err, e.err);
         check("phaseupdown_latched", bus.pll_phaseupdown, e.dir);
         check("counter_select", bus.pll_phasecounterselect, CNT_SEL);
      end
   endtask

   task automatic resetDut();
      rst          = 1'b1;
      bus.step_req = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_done_n", bus.step_done_n, 1);
      check("rst_select", bus.pll_phasecounterselect, CNT_SEL);
      check("rst_updown", bus.pll_phaseupdown, 0);
      check("rst_phasestep", bus.pll_phasestep, 0);
      check("rst_busy", busy, 0);
      check("rst_tap", tap_pos, 0);
      check("rst_timeout", timeout_err, 0);
      rst       = 1'b0;
      model_tap = 0;
      model_err = 0;
      exp_q.delete();
   endtask

   task automatic applyStimulus(input logic dir, input bit toggle_dir, input bit drop_early,
                                input bit expect_timeout, input int latency);
      int   cycles;
      exp_t e;
      if (expect_timeout) model_err = 1;
      else                model_tap = satTap(model_tap + (dir ? -1 : 1));
      e.tap = model_tap;
      e.err = model_err;
      e.dir = dir ? 1 : 0;
      exp_q.push_back(e);

      @(posedge clock);
      #1;
      bus.step_req = 1'b1;
      bus.step_dir = dir;
      cycles       = 0;
      while (bus.step_done_n !== 1'b0 && cycles < WAIT_BUDGET) begin
         @(posedge clock);
         #1;
         cycles++;
         check("phasestep_profile", bus.pll_phasestep, (cycles >= 2 && cycles <= 1 + STEP_HOLD));
         check("busy_during_step", busy, 1);
         if (toggle_dir) bus.step_dir = ~bus.step_dir;
         if (drop_early && bus.pll_phasestep) bus.step_req = 1'b0;
      end
      check("done_latency", cycles, latency);
      checkOutput();

      bus.step_req = 1'b0;
      @(posedge clock);
      #1;
      check("done_n_release", bus.step_done_n, 1);
      check("idle_after_release", busy, 0);
      @(posedge clock);
      #1;
      check("busy_rearm", busy, 0);
   endtask

   task automatic resetMidStep();
      @(posedge clock);
      #1;
      bus.step_req = 1'b1;
      bus.step_dir = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("phasestep_before_reset", bus.pll_phasestep, 1);
      rst          = 1'b1;
      bus.step_req = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_phasestep", bus.pll_phasestep, 0);
      check("midrst_tap", tap_pos, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done_n", bus.step_done_n, 1);
      check("midrst_timeout", timeout_err, 0);
      rst       = 1'b0;
      model_tap = 0;
      model_err = 0;
      exp_q.delete();
      repeat (12) @(posedge clock);
      #1;
   endtask

   initial begin
      bus.step_req = 1'b0;
      bus.step_dir = 1'b0;
      rst          = 1'b1;

      $display("[TB] reset values");
      resetDut();

      $display("[TB] single advance step");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, DONE_LATENCY);

      $display("[TB] delay saturation");
      resetDut();
      for (int i = 1; i <= 130; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, DONE_LATENCY);
         if (i >= 128) check("tap_saturated", tap_pos, -128);
      end
      check("no_timeout_after_sat", timeout_err, 0);

      $display("[TB] direction latch with toggling step_dir");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, DONE_LATENCY);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, DONE_LATENCY);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, DONE_LATENCY);

      $display("[TB] stuck PLL timeout");
      pll_stuck = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, TIMEOUT_LATENCY);
      pll_stuck = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, DONE_LATENCY);

      $display("[TB] early request drop");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, DONE_LATENCY);

      $display("[TB] reset during phasestep");
      resetMidStep();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, DONE_LATENCY);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
